dev_dumper: RTL and testbench

DEV_DUMPER -- requirements
Module: dev_dumper

---
 rtl/dev_dumper.sv | 152 +++++++++++++++
 tb/tb_dev_dumper.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dev_dumper.sv
// Streams a block of RAM to a character pipe as uppercase hex text,
// LINE_BYTES bytes per line, each line terminated by a single 0x0A.
module dev_dumper #(
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 16,
    parameter int LINE_BYTES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data_out,
    output logic [7:0]        tx_data,
    output logic              tx_push_back,
    input  logic              tx_full,
    output logic              busy,
    output logic              done
);

    localparam int                LINE_W    = $clog2(LINE_BYTES + 1);
    localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(LINE_BYTES);

    typedef enum logic [2:0] {IDLE, REQ, CAPT, HI, LO, NL, FIN} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [LEN_W-1:0]  r_rem;
    logic [LEN_W-1:0]  w_rem_next;
    logic [LINE_W-1:0] r_line;
    logic [LINE_W-1:0] w_line_next;
    logic [7:0]        r_byte;
    logic [7:0]        w_byte_next;
    logic [7:0]        r_tx_data;
    logic [7:0]        w_tx_data_next;
    logic              r_push;
    logic              w_push_next;

    logic [ADDR_W-1:0] w_addr_inc;
    logic [LEN_W-1:0]  w_rem_dec;
    logic [LINE_W-1:0] w_line_inc;

    function automatic logic [7:0] f_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    assign w_addr_inc = r_addr + ADDR_W'(1);
    assign w_rem_dec  = r_rem - LEN_W'(1);
    assign w_line_inc = r_line + LINE_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_line    <= '0;
            r_byte    <= '0;
            r_tx_data <= '0;
            r_push    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_rem     <= w_rem_next;
            r_line    <= w_line_next;
            r_byte    <= w_byte_next;
            r_tx_data <= w_tx_data_next;
            r_push    <= w_push_next;
        end
    end

    // Each character is loaded into r_tx_data one cycle before its strobe;
    // the strobe cycle itself is what moves the FSM on to the next character.
    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_rem_next     = r_rem;
        w_line_next    = r_line;
        w_byte_next    = r_byte;
        w_tx_data_next = r_tx_data;
        w_push_next    = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_addr_next  = start_addr;
                    w_rem_next   = len;
                    w_line_next  = '0;
                    w_state_next = (len == '0) ? FIN : REQ;
                end
            end
            REQ: begin
                w_state_next = CAPT;
            end
            CAPT: begin
                w_byte_next    = ram_data_out;
                w_tx_data_next = f_hex(ram_data_out[7:4]);
                w_state_next   = HI;
            end
            HI: begin
                if (r_push) begin
                    w_tx_data_next = f_hex(r_byte[3:0]);
                    w_state_next   = LO;
                end else begin
                    w_tx_data_next = f_hex(r_byte[7:4]);
                    w_push_next    = !tx_full;
                end
            end
            LO: begin
                if (r_push) begin
                    w_addr_next = w_addr_inc;
                    w_rem_next  = w_rem_dec;
                    w_line_next = w_line_inc;
                    if ((w_line_inc == LINE_FULL) || (w_rem_dec == '0)) begin
                        w_tx_data_next = 8'h0A;
                        w_state_next   = NL;
                    end else begin
                        w_state_next = REQ;
                    end
                end else begin
                    w_push_next = !tx_full;
                end
            end
            NL: begin
                if (r_push) begin
                    w_line_next  = '0;
                    w_state_next = (r_rem == '0) ? FIN : REQ;
                end else begin
                    w_push_next = !tx_full;
                end
            end
            FIN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign ram_addr     = r_addr;
    assign tx_data      = r_tx_data;
    assign tx_push_back = r_push;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == FIN);

endmodule

// File: tb/tb_dev_dumper.sv
// Directed bench for dev_dumper: RAM model, tx capture, hand-written expected text.
module tb_dev_dumper;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] start_addr;
    logic [15:0] len;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data_out;
    logic [7:0]  tx_data;
    logic        tx_push_back;
    logic        tx_full;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:65535];
    logic [7:0]  got [$];
    int          done_cnt;
    int          busy_cyc;
    int          n_cmp;
    int          n_bad;

    dev_dumper #(
        .ADDR_W    (16),
        .LEN_W     (16),
        .LINE_BYTES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .len         (len),
        .ram_addr    (ram_addr),
        .ram_data_out(ram_data_out),
        .tx_data     (tx_data),
        .tx_push_back(tx_push_back),
        .tx_full     (tx_full),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ram_data_out <= mem[ram_addr];

    always @(negedge clk) begin
        if (tx_push_back) got.push_back(tx_data);
        if (done) done_cnt++;
        if (busy) busy_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_start(input logic [15:0] a, input logic [15:0] l);
        step();
        start      = 1'b1;
        start_addr = a;
        len        = l;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 3000) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 32'(done_cnt == base), 32'd0);
    endtask

    task automatic wait_strobes(input string tag, input int cnt);
        int n;
        n = 0;
        while (got.size() < cnt && n < 3000) begin
            step();
            n++;
        end
        chk({tag, "_strobe_timeout"}, 32'(got.size() < cnt), 32'd0);
    endtask

    task automatic cmp_stream(input string tag, input string exp);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++) begin
            if (i < got.size()) chk($sformatf("%s_c%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        int d0;
        int s0;
        n_cmp      = 0;
        n_bad      = 0;
        done_cnt   = 0;
        busy_cyc   = 0;
        rst        = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        tx_full    = 1'b0;
        mem[0] = 8'h00; mem[1] = 8'hA5; mem[2] = 8'hFF;
        for (int i = 0; i < 17; i++) mem[16'h0100 + i] = 8'(i);
        mem[16'hFFFF] = 8'h3C;

        // reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_push", 32'(tx_push_back), 32'd0);
        chk("rst_txdata", 32'(tx_data), 32'h00);
        chk("rst_ramaddr", 32'(ram_addr), 32'h0000);
        rst = 1'b1;
        step();

        // three bytes, one line
        got.delete();
        busy_cyc = 0;
        d0 = done_cnt;
        run_start(16'h0000, 16'd3);
        wait_done("t1", d0);
        step();
        cmp_stream("t1", "00A5FF\n");
        chk("t1_done", 32'(done_cnt - d0), 32'd1);
        chk("t1_throughput", 32'(busy_cyc <= 21), 32'd1);

        // 17 bytes crosses a line boundary
        got.delete();
        d0 = done_cnt;
        run_start(16'h0100, 16'd17);
        wait_done("t2", d0);
        step();
        cmp_stream("t2", "000102030405060708090A0B0C0D0E0F\n10\n");
        chk("t2_done", 32'(done_cnt - d0), 32'd1);

        // empty dump
        got.delete();
        busy_cyc = 0;
        d0 = done_cnt;
        run_start(16'h0000, 16'd0);
        chk("t3_fin_busy", 32'(busy), 32'd1);
        chk("t3_fin_done", 32'(done), 32'd1);
        step();
        chk("t3_after_busy", 32'(busy), 32'd0);
        chk("t3_after_done", 32'(done), 32'd0);
        chk("t3_busy_cycles", 32'(busy_cyc), 32'd1);
        chk("t3_strobes", 32'(got.size()), 32'd0);
        chk("t3_done", 32'(done_cnt - d0), 32'd1);

        // 50-cycle stall between the two characters of byte 1
        got.delete();
        d0 = done_cnt;
        run_start(16'h0000, 16'd3);
        wait_strobes("t4", 3);
        tx_full = 1'b1;
        s0 = got.size();
        repeat (50) step();
        chk("t4_stall_strobes", 32'(got.size()), 32'(s0));
        tx_full = 1'b0;
        wait_done("t4", d0);
        step();
        cmp_stream("t4", "00A5FF\n");
        chk("t4_done", 32'(done_cnt - d0), 32'd1);

        // address wraps from 0xFFFF to 0x0000
        got.delete();
        d0 = done_cnt;
        run_start(16'hFFFF, 16'd2);
        wait_done("t5", d0);
        step();
        cmp_stream("t5", "3C00\n");

        // reset after the third strobe aborts the dump
        got.delete();
        d0 = done_cnt;
        run_start(16'h0000, 16'd3);
        wait_strobes("t6", 3);
        rst = 1'b0;
        #1;
        chk("t6_push", 32'(tx_push_back), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_txdata", 32'(tx_data), 32'h00);
        chk("t6_ramaddr", 32'(ram_addr), 32'h0000);
        repeat (10) step();
        chk("t6_no_more_strobes", 32'(got.size()), 32'd3);
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        rst = 1'b1;
        step();
        got.delete();
        d0 = done_cnt;
        run_start(16'h0000, 16'd3);
        wait_done("t6r", d0);
        step();
        cmp_stream("t6r", "00A5FF\n");
        chk("t6r_done", 32'(done_cnt - d0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
